// File: rtl/bp_update_scheduler.sv
// Arbitrates two branch-resolution ports onto the PD-stage predictor training/recovery port.
// Optional perf counters are enabled by defining BPU_SCHED_PERF_EN.
module bp_update_scheduler #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned PHT_ADDRESS    = 9,
  parameter int unsigned GHR_SIZE       = 9,
  parameter int unsigned RAS_ADDRESS    = 3,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [XLEN-1:0]            req0_pc,
  input  logic [XLEN-1:0]            req0_target,
  input  logic                       req0_taken,
  input  logic                       req0_is_branch,
  input  logic                       req0_is_ret,
  input  logic                       req0_is_call,
  input  logic                       req0_mispredict,
  input  logic [PHT_ADDRESS-1:0]     req0_pht_index,
  input  logic [GHR_SIZE-1:0]        req0_ghr_snap,
  input  logic [RAS_ADDRESS-1:0]     req0_sp_snap,
  input  logic [2*XLEN-1:0]          req0_ras_snap,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [XLEN-1:0]            req1_pc,
  input  logic [XLEN-1:0]            req1_target,
  input  logic                       req1_taken,
  input  logic                       req1_is_branch,
  input  logic                       req1_is_ret,
  input  logic                       req1_is_call,
  input  logic                       req1_mispredict,
  input  logic [PHT_ADDRESS-1:0]     req1_pht_index,
  input  logic [GHR_SIZE-1:0]        req1_ghr_snap,
  input  logic [RAS_ADDRESS-1:0]     req1_sp_snap,
  input  logic [2*XLEN-1:0]          req1_ras_snap,
  output logic                       mispredict,
  output logic                       restore_ghr,
  output logic                       restore_ras,
  output logic                       update_pht,
  output logic                       update_btb,
  output logic                       update_ras,
  output logic                       actual_taken,
  output logic                       ex_is_branch,
  output logic                       ex_is_ret,
  output logic [XLEN-1:0]            ex_pc,
  output logic [XLEN-1:0]            actual_target_address,
  output logic [XLEN-1:0]            actual_return_address,
  output logic [PHT_ADDRESS-1:0]     rb_pht_index,
  output logic [GHR_SIZE-1:0]        ghr_snap,
  output logic [RAS_ADDRESS-1:0]     rb_sp_snap,
  output logic [2*XLEN-1:0]          rb_ras_snap,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                       busy
`ifdef BPU_SCHED_PERF_EN
  ,
  output logic [31:0]                perf_mispredict_cnt,
  output logic [31:0]                perf_stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RC_W  = $clog2(RECOVER_CYCLES + 1);

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        target;
    logic                   taken;
    logic                   is_branch;
    logic                   is_ret;
    logic                   is_call;
    logic [PHT_ADDRESS-1:0] pht_index;
    logic [GHR_SIZE-1:0]    ghr_snap;
    logic [RAS_ADDRESS-1:0] sp_snap;
    logic [2*XLEN-1:0]      ras_snap;
  } entry_t;

  typedef enum logic [1:0] {IDLE, DRAIN, RECOVER} state_t;

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  logic             rr_q, rr_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  entry_t           fifo_mem [FIFO_DEPTH];

  entry_t req0_e, req1_e, head_e, out_e;
  logic   mp_acc, mp_sel, enq, enq_sel, pop, full;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    req0_e = '{pc: req0_pc, target: req0_target, taken: req0_taken, is_branch: req0_is_branch,
               is_ret: req0_is_ret, is_call: req0_is_call, pht_index: req0_pht_index,
               ghr_snap: req0_ghr_snap, sp_snap: req0_sp_snap, ras_snap: req0_ras_snap};
    req1_e = '{pc: req1_pc, target: req1_target, taken: req1_taken, is_branch: req1_is_branch,
               is_ret: req1_is_ret, is_call: req1_is_call, pht_index: req1_pht_index,
               ghr_snap: req1_ghr_snap, sp_snap: req1_sp_snap, ras_snap: req1_ras_snap};
  end

  assign head_e = fifo_mem[rd_ptr_q];
  assign full   = (fifo_count == CNT_W'(FIFO_DEPTH));

  // Arbitration, ready generation and next-state logic
  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    rr_d       = rr_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    mp_acc     = 1'b0;
    mp_sel     = 1'b0;
    enq        = 1'b0;
    enq_sel    = 1'b0;
    pop        = 1'b0;
    cnt_next   = fifo_count;
    case (state_q)
      RECOVER: begin
        if (rcnt_q <= RC_W'(1)) begin
          rcnt_d  = '0;
          state_d = (fifo_count != '0) ? DRAIN : IDLE;
        end else begin
          rcnt_d = rcnt_q - RC_W'(1);
        end
      end
      default: begin
        // Mispredicts win over training and ignore FIFO fullness
        if (req0_valid && req0_mispredict) begin
          mp_acc     = 1'b1;
          req0_ready = 1'b1;
        end else if (req1_valid && req1_mispredict) begin
          mp_acc     = 1'b1;
          mp_sel     = 1'b1;
          req1_ready = 1'b1;
        end else if (!full) begin
          if (req0_valid && req1_valid) begin
            enq     = 1'b1;
            enq_sel = rr_q;
          end else if (req0_valid || req1_valid) begin
            enq     = 1'b1;
            enq_sel = req1_valid;
          end
          if (enq) begin
            req0_ready = ~enq_sel;
            req1_ready = enq_sel;
            rr_d       = ~enq_sel;
          end
        end
        pop      = (state_q == DRAIN) && !mp_acc;
        cnt_next = fifo_count + CNT_W'(enq) - CNT_W'(pop);
        if (mp_acc) begin
          state_d = RECOVER;
          rcnt_d  = RC_W'(RECOVER_CYCLES);
        end else begin
          state_d = (cnt_next != '0) ? DRAIN : IDLE;
        end
      end
    endcase
  end

  assign out_e = mp_acc ? (mp_sel ? req1_e : req0_e) : head_e;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rcnt_q     <= '0;
      rr_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      rr_q       <= rr_d;
      fifo_count <= cnt_next;
      if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage is not reset; pointers define validity
  always_ff @(posedge CLK) begin
    if (enq) fifo_mem[wr_ptr_q] <= enq_sel ? req1_e : req0_e;
  end

  // Registered predictor port: strobes pulse, data holds between issues
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      mispredict            <= 1'b0;
      restore_ghr           <= 1'b0;
      restore_ras           <= 1'b0;
      update_pht            <= 1'b0;
      update_btb            <= 1'b0;
      update_ras            <= 1'b0;
      actual_taken          <= 1'b0;
      ex_is_branch          <= 1'b0;
      ex_is_ret             <= 1'b0;
      ex_pc                 <= '0;
      actual_target_address <= '0;
      actual_return_address <= '0;
      rb_pht_index          <= '0;
      ghr_snap              <= '0;
      rb_sp_snap            <= '0;
      rb_ras_snap           <= '0;
      busy                  <= 1'b0;
    end else begin
      mispredict  <= mp_acc;
      restore_ghr <= mp_acc;
      restore_ras <= mp_acc;
      update_pht  <= mp_acc | (pop & head_e.is_branch);
      update_btb  <= mp_acc | pop;
      update_ras  <= (mp_acc | pop) & out_e.is_call;
      busy        <= (state_d != IDLE);
      if (mp_acc || pop) begin
        actual_taken          <= out_e.taken;
        ex_is_branch          <= out_e.is_branch;
        ex_is_ret             <= out_e.is_ret;
        ex_pc                 <= out_e.pc;
        actual_target_address <= out_e.target;
        actual_return_address <= out_e.pc + XLEN'(4);
        rb_pht_index          <= out_e.pht_index;
        ghr_snap              <= out_e.ghr_snap;
        rb_sp_snap            <= out_e.sp_snap;
        rb_ras_snap           <= out_e.ras_snap;
      end
    end
  end

`ifdef BPU_SCHED_PERF_EN
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      perf_mispredict_cnt <= '0;
      perf_stall_cnt      <= '0;
    end else begin
      if (mp_acc) perf_mispredict_cnt <= perf_mispredict_cnt + 32'd1;
      if ((req0_valid && !req0_ready) || (req1_valid && !req1_ready))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Bench for bp_update_scheduler: directed vector table, corner sequences and a queue-based reference model.
module tb_bp_update_scheduler;

  localparam int unsigned DEPTH = 8;
  localparam int RC = 2;

  typedef struct packed {
    logic        valid, mispredict, taken, is_branch, is_ret, is_call;
    logic [31:0] pc, target;
    logic [8:0]  pht;
    logic [8:0]  ghr;
    logic [2:0]  sp;
    logic [63:0] ras;
  } req_t;

  typedef struct packed {
    logic        mp, rghr, rras, upht, ubtb, uras, taken, isbr, isret;
    logic [31:0] pc, target, ret;
    logic [8:0]  pht;
    logic [8:0]  ghr;
    logic [2:0]  sp;
    logic [63:0] ras;
    logic [3:0]  cnt;
    logic        busy;
  } out_t;

  typedef struct {
    logic v0, mp0; logic [31:0] pc0;
    logic v1, mp1; logic [31:0] pc1;
    logic er0, er1, emp, ebtb; logic [31:0] epc; int ecnt;
  } vec_t;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  req_t r0, r1;
  logic req0_ready, req1_ready;
  logic mispredict, restore_ghr, restore_ras, update_pht, update_btb, update_ras;
  logic actual_taken, ex_is_branch, ex_is_ret, busy;
  logic [31:0] ex_pc, actual_target_address, actual_return_address;
  logic [8:0] rb_pht_index, ghr_snap;
  logic [2:0] rb_sp_snap;
  logic [63:0] rb_ras_snap;
  logic [3:0] fifo_count;

  int total = 0;
  int bad = 0;

  req_t mq[$];
  int   rec_left;
  bit   m_rr;
  out_t m_out;

  always #5 CLK = ~CLK;

  bp_update_scheduler dut (
    .CLK(CLK), .reset(reset),
    .req0_valid(r0.valid), .req0_ready(req0_ready), .req0_pc(r0.pc), .req0_target(r0.target),
    .req0_taken(r0.taken), .req0_is_branch(r0.is_branch), .req0_is_ret(r0.is_ret),
    .req0_is_call(r0.is_call), .req0_mispredict(r0.mispredict), .req0_pht_index(r0.pht),
    .req0_ghr_snap(r0.ghr), .req0_sp_snap(r0.sp), .req0_ras_snap(r0.ras),
    .req1_valid(r1.valid), .req1_ready(req1_ready), .req1_pc(r1.pc), .req1_target(r1.target),
    .req1_taken(r1.taken), .req1_is_branch(r1.is_branch), .req1_is_ret(r1.is_ret),
    .req1_is_call(r1.is_call), .req1_mispredict(r1.mispredict), .req1_pht_index(r1.pht),
    .req1_ghr_snap(r1.ghr), .req1_sp_snap(r1.sp), .req1_ras_snap(r1.ras),
    .mispredict(mispredict), .restore_ghr(restore_ghr), .restore_ras(restore_ras),
    .update_pht(update_pht), .update_btb(update_btb), .update_ras(update_ras),
    .actual_taken(actual_taken), .ex_is_branch(ex_is_branch), .ex_is_ret(ex_is_ret),
    .ex_pc(ex_pc), .actual_target_address(actual_target_address),
    .actual_return_address(actual_return_address), .rb_pht_index(rb_pht_index),
    .ghr_snap(ghr_snap), .rb_sp_snap(rb_sp_snap), .rb_ras_snap(rb_ras_snap),
    .fifo_count(fifo_count), .busy(busy)
  );

  function automatic out_t act();
    return '{mp: mispredict, rghr: restore_ghr, rras: restore_ras, upht: update_pht,
             ubtb: update_btb, uras: update_ras, taken: actual_taken, isbr: ex_is_branch,
             isret: ex_is_ret, pc: ex_pc, target: actual_target_address,
             ret: actual_return_address, pht: rb_pht_index, ghr: ghr_snap, sp: rb_sp_snap,
             ras: rb_ras_snap, cnt: fifo_count, busy: busy};
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    rec_left = 0;
    m_rr = 1'b0;
    m_out = '0;
  endtask

  // Who gets accepted this cycle, from the arbitration rules
  task automatic model_grant(output bit g0, output bit g1, output bit is_mp);
    g0 = 0; g1 = 0; is_mp = 0;
    if (rec_left == 0) begin
      if (r0.valid && r0.mispredict) begin g0 = 1; is_mp = 1; end
      else if (r1.valid && r1.mispredict) begin g1 = 1; is_mp = 1; end
      else if (mq.size() < DEPTH) begin
        if (r0.valid && r1.valid) begin
          if (m_rr) g1 = 1; else g0 = 1;
        end else if (r0.valid) g0 = 1;
        else if (r1.valid) g1 = 1;
      end
    end
  endtask

  task automatic model_load(input req_t e);
    m_out.taken = e.taken; m_out.isbr = e.is_branch; m_out.isret = e.is_ret;
    m_out.pc = e.pc; m_out.target = e.target; m_out.ret = e.pc + 32'd4;
    m_out.pht = e.pht; m_out.ghr = e.ghr; m_out.sp = e.sp; m_out.ras = e.ras;
  endtask

  task automatic model_edge(input bit g0, input bit g1, input bit is_mp);
    bit pop;
    req_t e;
    pop = (rec_left == 0) && !is_mp && (mq.size() > 0);
    {m_out.mp, m_out.rghr, m_out.rras, m_out.upht, m_out.ubtb, m_out.uras} = '0;
    if (rec_left > 0) rec_left--;
    if (is_mp) begin
      e = g0 ? r0 : r1;
      model_load(e);
      {m_out.mp, m_out.rghr, m_out.rras, m_out.upht, m_out.ubtb} = '1;
      m_out.uras = e.is_call;
      rec_left = RC;
    end else if (pop) begin
      e = mq.pop_front();
      model_load(e);
      m_out.upht = e.is_branch; m_out.ubtb = 1'b1; m_out.uras = e.is_call;
    end
    if (!is_mp && (g0 || g1)) begin
      mq.push_back(g0 ? r0 : r1);
      m_rr = g0;
    end
    m_out.cnt = 4'(mq.size());
    m_out.busy = (rec_left > 0) || (mq.size() > 0);
  endtask

  task automatic run_cycle();
    bit g0, g1, ism;
    #1;
    model_grant(g0, g1, ism);
    check("ready", 256'({req0_ready, req1_ready}), 256'({g0, g1}));
    @(posedge CLK);
    model_edge(g0, g1, ism);
    #1;
    check("outputs", 256'(act()), 256'(m_out));
    @(negedge CLK);
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.valid = ($urandom_range(0, 99) < 60);
    r.mispredict = ($urandom_range(0, 99) < 15);
    r.taken = 1'($urandom); r.is_branch = 1'($urandom);
    r.is_ret = 1'($urandom); r.is_call = 1'($urandom);
    r.pc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : $urandom;
    r.target = $urandom; r.pht = 9'($urandom); r.ghr = 9'($urandom);
    r.sp = 3'($urandom); r.ras = {$urandom, $urandom};
    return r;
  endfunction

  vec_t tbl[18];

  initial begin
    bit g0, g1, ism;
    //           v0 mp0 pc0        v1 mp1 pc1      r0 r1 mp btb pc        cnt
    tbl[0]  = '{1, 0, 32'h100, 0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   1};
    tbl[1]  = '{0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 1, 32'h100, 0};
    tbl[2]  = '{1, 0, 32'h110, 1, 0, 32'h120, 0, 1, 0, 0, 32'h100, 1};
    tbl[3]  = '{1, 0, 32'h110, 1, 0, 32'h130, 1, 0, 0, 1, 32'h120, 1};
    tbl[4]  = '{1, 0, 32'h140, 1, 0, 32'h130, 0, 1, 0, 1, 32'h110, 1};
    tbl[5]  = '{0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 1, 32'h130, 0};
    tbl[6]  = '{1, 1, 32'h200, 1, 1, 32'h300, 1, 0, 1, 1, 32'h200, 0};
    tbl[7]  = '{0, 0, 32'h0,   1, 1, 32'h300, 0, 0, 0, 0, 32'h200, 0};
    tbl[8]  = '{0, 0, 32'h0,   1, 1, 32'h300, 0, 0, 0, 0, 32'h200, 0};
    tbl[9]  = '{0, 0, 32'h0,   1, 1, 32'h300, 0, 1, 1, 1, 32'h300, 0};
    tbl[10] = '{1, 0, 32'h150, 0, 0, 32'h0,   0, 0, 0, 0, 32'h300, 0};
    tbl[11] = '{1, 0, 32'h150, 0, 0, 32'h0,   0, 0, 0, 0, 32'h300, 0};
    tbl[12] = '{1, 0, 32'h150, 0, 0, 32'h0,   1, 0, 0, 0, 32'h300, 1};
    tbl[13] = '{1, 1, 32'h400, 0, 0, 32'h0,   1, 0, 1, 1, 32'h400, 1};
    tbl[14] = '{0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 32'h400, 1};
    tbl[15] = '{0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 32'h400, 1};
    tbl[16] = '{0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 1, 32'h150, 0};
    tbl[17] = '{0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0, 32'h150, 0};

    r0 = '0; r1 = '0;
    model_reset();
    #1;
    check("reset_outputs", 256'(act()), 256'(out_t'(0)));
    repeat (2) @(negedge CLK);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      r0 = '0; r1 = '0;
      r0.valid = tbl[i].v0; r0.mispredict = tbl[i].mp0; r0.pc = tbl[i].pc0;
      r0.target = tbl[i].pc0 + 32'h1000; r0.taken = 1'b1; r0.is_branch = 1'b1;
      r1.valid = tbl[i].v1; r1.mispredict = tbl[i].mp1; r1.pc = tbl[i].pc1;
      r1.target = tbl[i].pc1 + 32'h1000; r1.taken = 1'b1; r1.is_branch = 1'b1;
      #1;
      check($sformatf("tbl_ready[%0d]", i), 256'({req0_ready, req1_ready}),
            256'({tbl[i].er0, tbl[i].er1}));
      model_grant(g0, g1, ism);
      @(posedge CLK);
      model_edge(g0, g1, ism);
      #1;
      check($sformatf("tbl_out[%0d]", i),
            256'({mispredict, update_btb, update_pht, ex_pc, fifo_count}),
            256'({tbl[i].emp, tbl[i].ebtb, tbl[i].ebtb, tbl[i].epc, 4'(tbl[i].ecnt)}));
      @(negedge CLK);
    end

    // Return address wraps at the top of the address space
    r0 = '0; r1 = '0;
    r0.valid = 1'b1; r0.is_call = 1'b1; r0.pc = 32'hFFFF_FFFC; r0.target = 32'h8000;
    run_cycle();
    r0 = '0;
    run_cycle();
    check("wrap_ras", 256'({update_ras, update_btb, mispredict}), 256'(3'b110));
    check("wrap_ret", 256'(actual_return_address), 256'(32'h0));

    // Asynchronous reset while draining
    r0.valid = 1'b1; r0.is_branch = 1'b1; r0.pc = 32'h500;
    run_cycle();
    r0 = '0;
    #2;
    reset = 1'b0;
    #1;
    check("async_rst", 256'(act()), 256'(out_t'(0)));
    model_reset();
    @(negedge CLK);
    reset = 1'b1;
    repeat (3) run_cycle();
    check("post_rst_quiet", 256'({update_btb, update_pht, mispredict, fifo_count}), 256'(0));

    for (int i = 0; i < 3000; i++) begin
      r0 = rand_req();
      r1 = rand_req();
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
